sram_axi_slave: RTL
===================

# sram_axi_slave

AXI4 slave wrapper that terminates one slave port of the system AXI bus and drives a single-port word-addressed SRAM macro. It is the downstream endpoint for the CPU wrapper's instruction-fetch (M0) and data read/write (M1) transactions once they have been routed by the bus. It accepts one transaction at a time and supports single-beat and INCR/FIXED bursts up to 16 beats, with byte-strobed writes.

## Interface
- ID_W, 8: slave-side ID width (master ID plus bus-prepended master index).
- MEM_AW, 14: SRAM word-address width (2^14 words = 64 KiB).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S/ARVALID_S  in  ID_W/32/4/3/2/1  read address channel; ARREADY_S out 1.
- RID_S/RDATA_S/RRESP_S/RLAST_S/RVALID_S  out  ID_W/32/2/1/1  read data channel; RREADY_S in 1.
- AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S/AWVALID_S  in  ID_W/32/4/3/2/1  write address channel; AWREADY_S out 1.
- WDATA_S/WSTRB_S/WLAST_S/WVALID_S  in  32/4/1/1  write data channel; WREADY_S out 1.
- BID_S/BRESP_S/BVALID_S  out  ID_W/2/1  write response channel; BREADY_S in 1.
- sram_cs  out  1  macro chip select, active-high.
- sram_oe  out  1  macro read enable, active-high.
- sram_web  out  4  per-byte write enable, active-low (4'hF = no write).
- sram_a  out  MEM_AW  word address.
- sram_di  out  32  write data.
- sram_do  in  32  read data; valid the cycle after an enabled read, held by the macro until the next enabled access.

## Operation
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE: AWREADY_S = 1; ARREADY_S = !AWVALID_S (write wins a simultaneous request). AW handshake -> latch AWID/AWADDR/AWLEN/AWBURST, beat count 0, -> WR_DATA. AR handshake -> latch read fields, beat count 0, -> RD_REQ.
- RD_REQ: sram_cs=1, sram_oe=1, sram_a = latched addr[MEM_AW+1:2]; unconditionally -> RD_DATA.
- RD_DATA: RVALID_S=1, RDATA_S=sram_do, RID_S=latched ID, RRESP_S=2'b00, RLAST_S = (beat count == len). SRAM not enabled here. On RREADY_S: if RLAST_S -> IDLE, else advance address, count+1, -> RD_REQ.
- WR_DATA: WREADY_S=1. On WVALID_S: sram_cs=1, sram_web = ~WSTRB_S, sram_a = latched word addr, sram_di = WDATA_S in that same cycle. Burst ends on WLAST_S or count == len, whichever first -> WR_RESP; otherwise advance address, count+1.
- WR_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S = 2'b00 if WLAST_S coincided with count == len, else 2'b10 (SLVERR, the write itself is still performed). On BREADY_S -> IDLE.
- Address advance: ARBURST/AWBURST 2'b00 (FIXED) keeps address; 2'b01 (INCR) and 2'b10 (WRAP, treated as INCR) add 4. The word index wraps modulo 2^MEM_AW; bits above MEM_AW+1 are ignored.
- ARSIZE/AWSIZE are ignored: every beat is 32 bits, and byte lanes come only from WSTRB_S.
- When RVALID_S=0, RDATA_S, RID_S and RLAST_S are 0. When BVALID_S=0, BID_S and BRESP_S are 0.

## Timing
- Reset: state IDLE, latched fields and count 0, all VALID/READY outputs 0 during rst, sram_cs=0, sram_oe=0, sram_web=4'hF. rst asserted mid-burst aborts the burst without a response.
- Read latency: AR handshake at edge k -> RVALID_S at cycle k+2. Each later beat takes 2 cycles when RREADY_S is held high.
- Write: each W beat is written on the edge at which it is accepted. BVALID_S rises the cycle after the final W handshake.
- RVALID_S and BVALID_S stay high with stable payload until accepted; sram_do stability during stall is guaranteed because the SRAM is not re-enabled.
- One outstanding transaction: AR and AW are not accepted outside IDLE.

## Test plan
- Single read: preload word 0x40 = 0xDEADBEEF; AR addr 0x100, len 0, ID 0x12 -> RVALID 2 cycles later, RDATA 0xDEADBEEF, RID 0x12, RLAST 1, RRESP 0.
- Byte write: AW 0x104, W 0x11223344, WSTRB 4'b0010, WLAST 1 over old word 0 -> sram_web 4'b1101, word reads back 0x00003300, BRESP 0.
- INCR read burst: len 3 at 0x0 with RREADY toggling -> 4 beats of words 0-3 in order, payload held while stalled, RLAST only on beat 4.
- Simultaneous AR+AW in IDLE -> AWREADY taken first, ARREADY 0; read served after BREADY.
- Early WLAST: AWLEN 3, WLAST on beat 2 -> 2 words written, BRESP 2'b10; address 0xFFFC INCR len 1 -> second beat wraps to word 0.
- Reset asserted in RD_DATA -> next cycle RVALID 0, ARREADY 1 (AWVALID 0).

Source files
------------

// File: rtl/sram_axi_slave.sv
// AXI4 slave terminating one bus port onto a single-port word-addressed SRAM macro.
// Latency: read data 2 cycles after AR handshake, 2 cycles per read beat; writes land on the W handshake edge.
// Backpressure: one transaction at a time; R/B payloads held stable until RREADY_S/BREADY_S.
// Ports: clk/rst; AXI AR, R, AW, W and B channels (*_S); SRAM macro pins sram_cs/oe/web/a/di/do.
module sram_axi_slave #(
   parameter int ID_W   = 8,
   parameter int MEM_AW = 14
) (
   input  logic              clk,
   input  logic              rst,
   // read address channel
   input  logic [ID_W-1:0]   ARID_S,
   input  logic [31:0]       ARADDR_S,
   input  logic [3:0]        ARLEN_S,
   input  logic [2:0]        ARSIZE_S,
   input  logic [1:0]        ARBURST_S,
   input  logic              ARVALID_S,
   output logic              ARREADY_S,
   // read data channel
   output logic [ID_W-1:0]   RID_S,
   output logic [31:0]       RDATA_S,
   output logic [1:0]        RRESP_S,
   output logic              RLAST_S,
   output logic              RVALID_S,
   input  logic              RREADY_S,
   // write address channel
   input  logic [ID_W-1:0]   AWID_S,
   input  logic [31:0]       AWADDR_S,
   input  logic [3:0]        AWLEN_S,
   input  logic [2:0]        AWSIZE_S,
   input  logic [1:0]        AWBURST_S,
   input  logic              AWVALID_S,
   output logic              AWREADY_S,
   // write data channel
   input  logic [31:0]       WDATA_S,
   input  logic [3:0]        WSTRB_S,
   input  logic              WLAST_S,
   input  logic              WVALID_S,
   output logic              WREADY_S,
   // write response channel
   output logic [ID_W-1:0]   BID_S,
   output logic [1:0]        BRESP_S,
   output logic              BVALID_S,
   input  logic              BREADY_S,
   // SRAM macro
   output logic              sram_cs,
   output logic              sram_oe,
   output logic [3:0]        sram_web,
   output logic [MEM_AW-1:0] sram_a,
   output logic [31:0]       sram_di,
   input  logic [31:0]       sram_do
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   id_q, id_nxt;
   logic [31:0]       addr_q, addr_nxt;
   logic [3:0]        len_q, len_nxt;
   logic [3:0]        cnt_q, cnt_nxt;
   logic [1:0]        burst_q, burst_nxt;
   logic              err_q, err_nxt;
   logic [31:0]       addr_adv;
   logic              last_beat;

   // Beat size is always one word, so the size fields carry no information here.
   logic unused_size;
   assign unused_size = ^{ARSIZE_S, AWSIZE_S};

   // FIXED holds the address; INCR and WRAP both step one word. The 32-bit add
   // wraps the word index naturally because only addr[MEM_AW+1:2] reaches the macro.
   assign addr_adv  = (burst_q == 2'b00) ? addr_q : addr_q + 32'd4;
   assign last_beat = (cnt_q == len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         id_q    <= id_nxt;
         addr_q  <= addr_nxt;
         len_q   <= len_nxt;
         cnt_q   <= cnt_nxt;
         burst_q <= burst_nxt;
         err_q   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      id_nxt    = id_q;
      addr_nxt  = addr_q;
      len_nxt   = len_q;
      cnt_nxt   = cnt_q;
      burst_nxt = burst_q;
      err_nxt   = err_q;
      ARREADY_S = 1'b0;
      AWREADY_S = 1'b0;
      WREADY_S  = 1'b0;
      RVALID_S  = 1'b0;
      RID_S     = '0;
      RDATA_S   = '0;
      RRESP_S   = 2'b00;
      RLAST_S   = 1'b0;
      BVALID_S  = 1'b0;
      BID_S     = '0;
      BRESP_S   = 2'b00;
      sram_cs   = 1'b0;
      sram_oe   = 1'b0;
      sram_web  = 4'hF;
      sram_a    = addr_q[MEM_AW+1:2];
      sram_di   = '0;

      // Outputs are forced quiet while rst is held, even though state only
      // clears on the edge.
      if (!rst) begin
         unique case (state)
            IDLE: begin
               AWREADY_S = 1'b1;
               ARREADY_S = !AWVALID_S;   // write wins a simultaneous request
               if (AWVALID_S) begin
                  id_nxt    = AWID_S;
                  addr_nxt  = AWADDR_S;
                  len_nxt   = AWLEN_S;
                  burst_nxt = AWBURST_S;
                  cnt_nxt   = '0;
                  err_nxt   = 1'b0;
                  state_nxt = WR_DATA;
               end else if (ARVALID_S) begin
                  id_nxt    = ARID_S;
                  addr_nxt  = ARADDR_S;
                  len_nxt   = ARLEN_S;
                  burst_nxt = ARBURST_S;
                  cnt_nxt   = '0;
                  state_nxt = RD_REQ;
               end
            end
            RD_REQ: begin
               sram_cs   = 1'b1;
               sram_oe   = 1'b1;
               state_nxt = RD_DATA;
            end
            RD_DATA: begin
               // Macro is idle here, so sram_do stays stable through an R stall.
               RVALID_S = 1'b1;
               RDATA_S  = sram_do;
               RID_S    = id_q;
               RLAST_S  = last_beat;
               if (RREADY_S) begin
                  if (last_beat) begin
                     state_nxt = IDLE;
                  end else begin
                     addr_nxt  = addr_adv;
                     cnt_nxt   = cnt_q + 4'd1;
                     state_nxt = RD_REQ;
                  end
               end
            end
            WR_DATA: begin
               WREADY_S = 1'b1;
               if (WVALID_S) begin
                  sram_cs  = 1'b1;
                  sram_web = ~WSTRB_S;
                  sram_di  = WDATA_S;
                  if (WLAST_S || last_beat) begin
                     // Early WLAST or missing WLAST still writes the beat but reports SLVERR.
                     err_nxt   = !(WLAST_S && last_beat);
                     state_nxt = WR_RESP;
                  end else begin
                     addr_nxt = addr_adv;
                     cnt_nxt  = cnt_q + 4'd1;
                  end
               end
            end
            WR_RESP: begin
               BVALID_S = 1'b1;
               BID_S    = id_q;
               BRESP_S  = err_q ? 2'b10 : 2'b00;
               if (BREADY_S) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule
